// File: rtl/ucode_seq_mt_pkg.sv
// ucode_seq_mt_pkg
//   Shared types and constants for the multithreaded microcode sequencer.
//   - NUPCMSB: default micro-PC MSB (ROM depth 2**(NUPCMSB+1)).
//   - UPC_*: microcode entry points used by the decoder.
//   - UCIPOS_* / UCI_MASK: positions of the substitutable register fields and
//     their "take it from the macro instruction" flags inside a micro-instruction.
//   - microcode_out_type: 35-bit micro-op {uend, cwp_rs1, cwp_rd, inst}.
//   - ucode_state_type / ucode_thread_type: per-thread sequencer record.
//   - ucode_subst(): field substitution from the saved macro instruction.
package ucode_seq_mt_pkg;

    localparam int NUPCMSB = 4;

    // Microcode entry points.
    localparam logic [NUPCMSB:0] UPC_TRAP = 5'd0;
    localparam logic [NUPCMSB:0] UPC_ST   = 5'd4;
    localparam logic [NUPCMSB:0] UPC_LDD  = 5'd8;
    localparam logic [NUPCMSB:0] UPC_STD  = 5'd12;
    localparam logic [NUPCMSB:0] UPC_SWAP = 5'd16;
    localparam logic [NUPCMSB:0] UPC_ATOM = 5'd20;

    // Register fields and indirection flags inside the micro-instruction word.
    localparam int UCIPOS_RD      = 25;
    localparam int UCIPOS_RS1     = 14;
    localparam int UCIPOS_RS2     = 0;
    localparam int UCIPOS_RD_IND  = 29;
    localparam int UCIPOS_RS1_IND = 18;
    localparam int UCIPOS_RS2_IND = 4;
    localparam int UCIPOS_IMM     = 13;

    // Bits overwritten by substitution: rd[29:25], rs1[18:14], rs2[4:0].
    localparam logic [31:0] UCI_MASK = 32'h3E07_C01F;

    typedef struct packed {
        logic        uend;
        logic        cwp_rs1;
        logic        cwp_rd;
        logic [31:0] inst;
    } microcode_out_type;

    typedef enum logic [1:0] {
        UCS_IDLE = 2'd0,
        UCS_RUN  = 2'd1,
        UCS_DONE = 2'd2
    } ucode_state_type;

    typedef struct packed {
        ucode_state_type  state;
        logic [NUPCMSB:0] upc;
        logic [31:0]      inst;
    } ucode_thread_type;

    // Indirect fields take their value from the saved macro instruction; a
    // direct rd/rs1 is the 4-bit literal below its flag. rs2 is only indirect
    // for register-form ops (immediate bit clear).
    function automatic microcode_out_type ucode_subst(input microcode_out_type w,
                                                      input logic [31:0]      s);
        microcode_out_type o;
        o      = w;
        o.inst = w.inst & ~UCI_MASK;
        o.inst[UCIPOS_RD +: 5]  = w.inst[UCIPOS_RD_IND]  ? s[UCIPOS_RD +: 5]
                                                         : {1'b0, w.inst[UCIPOS_RD +: 4]};
        o.inst[UCIPOS_RS1 +: 5] = w.inst[UCIPOS_RS1_IND] ? s[UCIPOS_RS1 +: 5]
                                                         : {1'b0, w.inst[UCIPOS_RS1 +: 4]};
        o.inst[UCIPOS_RS2 +: 5] = (!w.inst[UCIPOS_IMM] && w.inst[UCIPOS_RS2_IND])
                                ? s[UCIPOS_RS2 +: 5] : w.inst[UCIPOS_RS2 +: 5];
        return o;
    endfunction

endpackage

// File: rtl/ucode_seq_mt_rom.sv
// ucode_rom
//   Patchable microcode store: 1R1W synchronous RAM with read-first behaviour
//   (a write and a read to the same address in one cycle return the old word).
//   Ports:
//     clk, srst          clock, synchronous reset of the read register
//     rd_en, rd_addr     read request; data appears on rd_data the next cycle
//     rd_data            registered read data (holds when rd_en=0)
//     wr_en, wr_addr,    patch write port
//     wr_data
//   ROMINIT names the power-up image; contents start all zero and are loaded
//   through the patch port.
module ucode_rom #(
    parameter int AW      = 5,
    parameter int DW      = 35,
    parameter     ROMINIT = ""
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_data_reg;

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = '0;
        end
    end

    // Both updates are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (srst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/ucode_seq_mt.sv
// ucode_seq_mt
//   Multithreaded microcode sequencer. Keeps {state, upc, saved macro inst}
//   per hardware thread, reads micro-instructions from a patchable ROM and
//   substitutes indirect rd/rs1/rs2 fields from the thread's macro instruction.
//   One micro-op per cycle, one-cycle latency from slot to out_*.
//   Ports:
//     gclk, rst                  clock, synchronous active-high reset
//     in_valid/in_tid/in_inst    thread slot and its macro instruction
//     in_start/in_upc            enter microcode at in_upc (IDLE/DONE threads)
//     in_replay                  reissue the thread's last micro-op
//     uc_we/uc_waddr/uc_wdata    ROM patch port
//     out_valid/out_tid/out_upc  issued micro-op identification
//     out_uc                     micro-op after field substitution
//     out_ovf                    pulse: a running thread stepped past the ROM end
//     run_mask                   bit t set while thread t is RUN or DONE
//   Threads must be interleaved (same tid never in consecutive slots); the
//   per-thread state is not forwarded between back-to-back slots.
module ucode_seq_mt
    import ucode_seq_mt_pkg::*;
#(
    parameter int NTHREAD = 64,
    parameter int NUPCMSB = 4,
    parameter     ROMINIT = "",
    localparam int TIDMSB = $clog2(NTHREAD) - 1
) (
    input  logic              gclk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [TIDMSB:0]   in_tid,
    input  logic [31:0]       in_inst,
    input  logic              in_start,
    input  logic [NUPCMSB:0]  in_upc,
    input  logic              in_replay,
    input  logic              uc_we,
    input  logic [NUPCMSB:0]  uc_waddr,
    input  logic [34:0]       uc_wdata,
    output logic              out_valid,
    output logic [TIDMSB:0]   out_tid,
    output logic [NUPCMSB:0]  out_upc,
    output logic [34:0]       out_uc,
    output logic              out_ovf,
    output logic [NTHREAD-1:0] run_mask
);

    // Per-thread record, LUTRAM style: read at the slot, written at the slot
    // (issue) and one cycle later (uend completion).
    ucode_state_type  state_mem [NTHREAD];
    logic [NUPCMSB:0] upc_mem   [NTHREAD];
    logic [31:0]      inst_mem  [NTHREAD];

    ucode_state_type  cur_state;
    logic [NUPCMSB:0] cur_upc;
    logic [31:0]      cur_inst;

    // Issue decision for the current slot.
    logic             issue_next;
    logic             update_next;
    logic             wrap_next;
    logic [NUPCMSB:0] addr_next;
    ucode_state_type  state_next;
    logic [31:0]      inst_next;

    // Output stage.
    logic              out_valid_reg;
    logic [TIDMSB:0]   out_tid_reg;
    logic [NUPCMSB:0]  out_upc_reg;
    logic [31:0]       subst_inst_reg;
    logic              ovf_reg;
    logic [NTHREAD-1:0] run_mask_reg;
    logic [34:0]       rom_word;
    microcode_out_type rom_uc;

    assign cur_state = state_mem[in_tid];
    assign cur_upc   = upc_mem[in_tid];
    assign cur_inst  = inst_mem[in_tid];

    always_comb begin
        issue_next  = 1'b0;
        update_next = 1'b0;
        wrap_next   = 1'b0;
        addr_next   = cur_upc;
        state_next  = cur_state;
        inst_next   = cur_inst;
        if (in_valid) begin
            case (cur_state)
                UCS_RUN: begin
                    if (in_replay) begin
                        issue_next  = 1'b1;
                        update_next = 1'b1;
                    end else if (&cur_upc) begin
                        // Stepping past the last ROM word: drop the thread.
                        wrap_next   = 1'b1;
                        update_next = 1'b1;
                        state_next  = UCS_IDLE;
                    end else begin
                        issue_next  = 1'b1;
                        update_next = 1'b1;
                        addr_next   = cur_upc + 1'b1;
                    end
                end
                UCS_DONE: begin
                    if (in_replay) begin
                        // Re-execute the final (uend) micro-op.
                        issue_next  = 1'b1;
                        update_next = 1'b1;
                        state_next  = UCS_RUN;
                    end else if (in_start) begin
                        issue_next  = 1'b1;
                        update_next = 1'b1;
                        addr_next   = in_upc;
                        inst_next   = in_inst;
                        state_next  = UCS_RUN;
                    end
                end
                default: begin
                    if (in_start) begin
                        issue_next  = 1'b1;
                        update_next = 1'b1;
                        addr_next   = in_upc;
                        inst_next   = in_inst;
                        state_next  = UCS_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            for (int i = 0; i < NTHREAD; i++) begin
                state_mem[i] <= UCS_IDLE;
                upc_mem[i]   <= '0;
                inst_mem[i]  <= '0;
            end
            out_valid_reg  <= 1'b0;
            out_tid_reg    <= '0;
            out_upc_reg    <= '0;
            subst_inst_reg <= '0;
            ovf_reg        <= 1'b0;
            run_mask_reg   <= '0;
        end else begin
            out_valid_reg <= issue_next;
            ovf_reg       <= wrap_next;
            if (issue_next) begin
                out_tid_reg    <= in_tid;
                out_upc_reg    <= addr_next;
                subst_inst_reg <= inst_next;
            end
            if (update_next) begin
                state_mem[in_tid]    <= state_next;
                upc_mem[in_tid]      <= addr_next;
                inst_mem[in_tid]     <= inst_next;
                run_mask_reg[in_tid] <= (state_next != UCS_IDLE);
            end
            // The thread that issued last cycle is RUN; a uend word ends it.
            // Interleaving guarantees this never targets the current slot's tid.
            if (out_valid_reg && rom_uc.uend) begin
                state_mem[out_tid_reg]    <= UCS_DONE;
                run_mask_reg[out_tid_reg] <= 1'b1;
            end
        end
    end

    ucode_rom #(
        .AW      (NUPCMSB + 1),
        .DW      (35),
        .ROMINIT (ROMINIT)
    ) u_rom (
        .clk     (gclk),
        .srst    (rst),
        .rd_en   (issue_next),
        .rd_addr (addr_next),
        .rd_data (rom_word),
        .wr_en   (uc_we),
        .wr_addr (uc_waddr),
        .wr_data (uc_wdata)
    );

    assign rom_uc    = microcode_out_type'(rom_word);
    assign out_valid = out_valid_reg;
    assign out_tid   = out_tid_reg;
    assign out_upc   = out_upc_reg;
    assign out_uc    = ucode_subst(rom_uc, subst_inst_reg);
    assign out_ovf   = ovf_reg;
    assign run_mask  = run_mask_reg;

endmodule

// File: tb/tb_ucode_seq_mt.sv
// tb_ucode_seq_mt
//   Directed bench for ucode_seq_mt: ROM patching, start/step/uend, replay
//   from RUN and DONE, ROM-end overflow, read-first patching, interleaved
//   threads and mid-sequence reset. Expected values are hand-computed.
module tb_ucode_seq_mt;

    localparam int NTHREAD = 64;
    localparam int NUPCMSB = 4;

    logic        gclk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  in_tid;
    logic [31:0] in_inst;
    logic        in_start;
    logic [4:0]  in_upc;
    logic        in_replay;
    logic        uc_we;
    logic [4:0]  uc_waddr;
    logic [34:0] uc_wdata;
    logic        out_valid;
    logic [5:0]  out_tid;
    logic [4:0]  out_upc;
    logic [34:0] out_uc;
    logic        out_ovf;
    logic [63:0] run_mask;

    int errors = 0;
    int checks = 0;
    int last_tid = -1;

    ucode_seq_mt #(
        .NTHREAD (NTHREAD),
        .NUPCMSB (NUPCMSB),
        .ROMINIT ("")
    ) dut (
        .gclk      (gclk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_tid    (in_tid),
        .in_inst   (in_inst),
        .in_start  (in_start),
        .in_upc    (in_upc),
        .in_replay (in_replay),
        .uc_we     (uc_we),
        .uc_waddr  (uc_waddr),
        .uc_wdata  (uc_wdata),
        .out_valid (out_valid),
        .out_tid   (out_tid),
        .out_upc   (out_upc),
        .out_uc    (out_uc),
        .out_ovf   (out_ovf),
        .run_mask  (run_mask)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1ns later.
    task automatic cyc(input logic v, input logic [5:0] tid, input logic [31:0] inst,
                       input logic st, input logic [4:0] upc, input logic rp,
                       input logic we, input logic [4:0] wa, input logic [34:0] wd);
        if (v) begin
            checks++;
            assert (last_tid != int'(tid)) else begin
                errors++;
                $error("FAIL interleave observed=tid%0d expected=not_tid%0d", tid, last_tid);
            end
        end
        last_tid  = v ? int'(tid) : -1;
        in_valid  = v;
        in_tid    = tid;
        in_inst   = inst;
        in_start  = st;
        in_upc    = upc;
        in_replay = rp;
        uc_we     = we;
        uc_waddr  = wa;
        uc_wdata  = wd;
        @(posedge gclk);
        #1;
        $display("txn rst=%0d v=%0d tid=%0d st=%0d upc=%0d rp=%0d we=%0d -> out_valid=%0d out_tid=%0d out_upc=%0d out_uc=%h ovf=%0d mask=%h",
                 rst, v, tid, st, upc, rp, we, out_valid, out_tid, out_upc, out_uc, out_ovf, run_mask);
    endtask

    task automatic idle();
        cyc(1'b0, 6'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 35'd0);
    endtask

    task automatic romw(input logic [4:0] a, input logic [34:0] d);
        cyc(1'b0, 6'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, a, d);
    endtask

    task automatic slot(input logic [5:0] tid, input logic [31:0] inst, input logic st,
                        input logic [4:0] upc, input logic rp);
        cyc(1'b1, tid, inst, st, upc, rp, 1'b0, 5'd0, 35'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset, then a single-op sequence ending in uend.
        rst = 1'b1;
        idle();
        idle();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_mask", run_mask, 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        chk("rst_uc", 64'(out_uc), 64'd0);
        rst = 1'b0;

        romw(5'd4,  35'h4_0000_0000);
        romw(5'd9,  35'h0_A004_0090);
        romw(5'd10, 35'h6_0000_2031);
        romw(5'd31, 35'h0_0000_0140);
        romw(5'd14, 35'h0_0000_0100);
        romw(5'd20, 35'h0_0000_0001);
        romw(5'd21, 35'h0_0000_0002);

        slot(6'd3, 32'd0, 1'b1, 5'd4, 1'b0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_tid", 64'(out_tid), 64'd3);
        chk("t1_upc", 64'(out_upc), 64'd4);
        chk("t1_uc", 64'(out_uc), 64'h4_0000_0000);
        chk("t1_mask", run_mask, 64'h8);
        idle();
        chk("t1_idle_valid", 64'(out_valid), 64'd0);
        chk("t1_mask_done", run_mask, 64'h8);
        slot(6'd3, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("t1_done_noissue", 64'(out_valid), 64'd0);

        // 2: substitution from the saved macro instruction, then step to uend.
        slot(6'd5, 32'h2202_5006, 1'b1, 5'd9, 1'b0);
        chk("t2_tid", 64'(out_tid), 64'd5);
        chk("t2_upc", 64'(out_upc), 64'd9);
        chk("t2_uc_subst", 64'(out_uc), 64'h0_A202_4086);
        idle();
        slot(6'd5, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("t2_step_valid", 64'(out_valid), 64'd1);
        chk("t2_step_upc", 64'(out_upc), 64'd10);
        chk("t2_step_uc", 64'(out_uc), 64'h6_0000_2031);
        idle();
        slot(6'd5, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("t2_end_valid", 64'(out_valid), 64'd0);
        chk("t2_mask", run_mask, 64'h28);

        // 3: replay from RUN and from DONE (replay beats in_start).
        slot(6'd2, 32'd0, 1'b1, 5'd9, 1'b0);
        chk("t3_upc", 64'(out_upc), 64'd9);
        idle();
        slot(6'd2, 32'd0, 1'b0, 5'd0, 1'b1);
        chk("t3_rep_valid", 64'(out_valid), 64'd1);
        chk("t3_rep_upc", 64'(out_upc), 64'd9);
        chk("t3_rep_uc", 64'(out_uc), 64'h0_8000_0080);
        idle();
        slot(6'd2, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("t3_step_upc", 64'(out_upc), 64'd10);
        idle();
        slot(6'd2, 32'd0, 1'b1, 5'd4, 1'b1);
        chk("t3_done_rep_valid", 64'(out_valid), 64'd1);
        chk("t3_done_rep_upc", 64'(out_upc), 64'd10);
        idle();
        slot(6'd2, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("t3_done_again", 64'(out_valid), 64'd0);

        // 4: running off the end of the ROM.
        slot(6'd7, 32'd0, 1'b1, 5'd31, 1'b0);
        chk("t4_upc", 64'(out_upc), 64'd31);
        chk("t4_uc", 64'(out_uc), 64'h0_0000_0140);
        chk("t4_mask_on", 64'(run_mask[7]), 64'd1);
        idle();
        slot(6'd7, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("t4_wrap_valid", 64'(out_valid), 64'd0);
        chk("t4_ovf", 64'(out_ovf), 64'd1);
        chk("t4_mask_off", 64'(run_mask[7]), 64'd0);
        idle();
        chk("t4_ovf_pulse", 64'(out_ovf), 64'd0);

        // 5: read-first ROM patch.
        cyc(1'b1, 6'd1, 32'd0, 1'b1, 5'd14, 1'b0, 1'b1, 5'd14, 35'h4_0000_0200);
        chk("t5_upc", 64'(out_upc), 64'd14);
        chk("t5_old_word", 64'(out_uc), 64'h0_0000_0100);
        idle();
        slot(6'd1, 32'd0, 1'b0, 5'd0, 1'b1);
        chk("t5_new_word", 64'(out_uc), 64'h4_0000_0200);

        // 6: interleaved threads 0/1, then reset mid-sequence.
        slot(6'd0, 32'd0, 1'b1, 5'd20, 1'b0);
        chk("t6_a_tid", 64'(out_tid), 64'd0);
        chk("t6_a_upc", 64'(out_upc), 64'd20);
        slot(6'd1, 32'd0, 1'b1, 5'd20, 1'b0);
        chk("t6_b_tid", 64'(out_tid), 64'd1);
        chk("t6_b_upc", 64'(out_upc), 64'd20);
        slot(6'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("t6_c_upc", 64'(out_upc), 64'd21);
        chk("t6_c_uc", 64'(out_uc), 64'h0_0000_0002);
        slot(6'd1, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("t6_d_tid", 64'(out_tid), 64'd1);
        chk("t6_d_upc", 64'(out_upc), 64'd21);
        rst = 1'b1;
        slot(6'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_mask", run_mask, 64'd0);
        chk("t6_rst_uc", 64'(out_uc), 64'd0);
        slot(6'd1, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("t6_idle_after_rst", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
